// File: rtl/uart_rx_fifo_if.sv
// Host-side read port of the UART receive FIFO.
// The head byte is valid whenever o_Rd_Valid=1; a pop happens on a cycle with i_Rd_En && o_Rd_Valid.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              i_Rd_En;
    logic [7:0]        o_Rd_Byte;
    logic              o_Rd_Valid;
    logic [ADDR_W:0]   o_Fifo_Count;
    logic              o_Full;

    modport slave (
        input  i_Rd_En,
        output o_Rd_Byte, o_Rd_Valid, o_Fifo_Count, o_Full
    );

    modport master (
        output i_Rd_En,
        input  o_Rd_Byte, o_Rd_Valid, o_Fifo_Count, o_Full
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1 / 8E1 / 8O1) feeding a first-word-fall-through FIFO,
// with sticky framing, parity and overrun flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Err_Clr,
    uart_rx_fifo_if.slave        rd,
    output logic                 o_Rx_Active,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Overrun,
    output logic [2:0]           o_Dbg_State
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] MID    = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic             sync1_q, rx_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_bad_q, par_bad_d;
    logic             push_req, frame_set, parity_set, bit_tick;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        rd_byte_q, rd_byte_d;
    logic              full, empty, do_pop, do_push, overrun_set;
    logic              frame_err_q, frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              overrun_q, overrun_d;

    assign bit_tick = (cnt_q == LAST);

    // Receiver FSM: every sample after the start-bit check lands on a counter wrap (mid-bit).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == MID) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        idx_d     = 3'd0;
                        par_bad_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    par_bad_d = ((^shift_q) ^ rx_s_q) != PARITY_ODD;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push_req   = 1'b1;
                        parity_set = par_bad_q;
                        state_d    = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign do_pop      = rd.i_Rd_En && !empty;
    assign do_push     = push_req && (!full || do_pop);
    assign overrun_set = push_req && full && !do_pop;

    // Head register tracks the post-update head; a byte written this cycle is bypassed.
    always_comb begin
        wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        rd_byte_d = rd_byte_q;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
        if (count_d != '0) begin
            if (do_push && (rd_ptr_d == wr_ptr_q)) rd_byte_d = shift_q;
            else                                  rd_byte_d = mem_q[rd_ptr_d];
        end
    end

    assign frame_err_d  = (frame_err_q  & ~i_Err_Clr) | frame_set;
    assign parity_err_d = (parity_err_q & ~i_Err_Clr) | parity_set;
    assign overrun_d    = (overrun_q    & ~i_Err_Clr) | overrun_set;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            par_bad_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_byte_q    <= 8'h00;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= i_Rx_Serial;
            rx_s_q       <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_byte_q    <= rd_byte_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rd.o_Rd_Byte    = rd_byte_q;
    assign rd.o_Rd_Valid   = !empty;
    assign rd.o_Fifo_Count = count_q;
    assign rd.o_Full       = full;
    assign o_Rx_Active     = (state_q != S_IDLE);
    assign o_Frame_Err     = frame_err_q;
    assign o_Parity_Err    = parity_err_q;
    assign o_Overrun       = overrun_q;
    assign o_Dbg_State     = state_q;

endmodule
